// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_ctrl_if
//  Description : Signal bundle between the commit stage / CP0 register file
//                and the exception sequencer. The master side is the
//                pipeline plus register file; the slave side is the
//                sequencer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_exc_ctrl_if #(
    parameter int ADDR_W = 5
);
    // Commit-stage event inputs
    logic              exc_int_en_i;
    logic [31:0]       pc_i;
    logic              in_delay_slot_i;
    logic [6:0]        exc_flags_i;
    logic              eret_i;
    logic [31:0]       badvaddr_i;

    // Current CP0 state
    logic [31:0]       status_i;
    logic [31:0]       cause_i;
    logic [31:0]       epc_i;

    // Pipeline MTC0 request
    logic              mtc0_req_i;
    logic [ADDR_W-1:0] mtc0_addr_i;
    logic [31:0]       mtc0_data_i;
    logic              mtc0_ack_o;

    // CP0 write port
    logic              cp0_we_o;
    logic [ADDR_W-1:0] cp0_waddr_o;
    logic [31:0]       cp0_wdata_o;

    // Pipeline control
    logic              flush_o;
    logic              stall_o;
    logic              redirect_valid_o;
    logic [31:0]       redirect_pc_o;

    modport master (
        output exc_int_en_i, pc_i, in_delay_slot_i, exc_flags_i, eret_i,
               badvaddr_i, status_i, cause_i, epc_i,
               mtc0_req_i, mtc0_addr_i, mtc0_data_i,
        input  mtc0_ack_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o,
               flush_o, stall_o, redirect_valid_o, redirect_pc_o
    );

    modport slave (
        input  exc_int_en_i, pc_i, in_delay_slot_i, exc_flags_i, eret_i,
               badvaddr_i, status_i, cause_i, epc_i,
               mtc0_req_i, mtc0_addr_i, mtc0_data_i,
        output mtc0_ack_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o,
               flush_o, stall_o, redirect_valid_o, redirect_pc_o
    );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_ctrl
//  Description : CP0 exception / interrupt sequencer and write-port arbiter.
//                Prioritises interrupts, committed exceptions and ERET,
//                sequences the EPC/CAUSE/STATUS/BADVADDR writes through the
//                single CP0 write port, arbitrates pipeline MTC0 writes onto
//                the same port and issues flush, stall and PC redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          ADDR_W     = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,     // synchronous, active low
    cp0_exc_ctrl_if.slave      bus
);

    // CP0 register numbers used by the sequencer
    localparam logic [ADDR_W-1:0] ADDR_BADV   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] ADDR_CAUSE  = ADDR_W'(13);
    localparam logic [ADDR_W-1:0] ADDR_EPC    = ADDR_W'(14);

    // Exception codes written to Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_EPC    = 3'd1,
        S_WR_CAUSE  = 3'd2,
        S_WR_STATUS = 3'd3,
        S_WR_BADV   = 3'd4,
        S_REDIRECT  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // Context captured at event acceptance
    logic [4:0]  excode_q;
    logic        bd_q;          // already resolved against a nested EXL
    logic [23:0] cause_hi_q;    // Cause[30:7], preserved across the write
    logic [31:0] epc_val_q;
    logic [31:0] badv_q;
    logic [31:0] status_q;
    logic [31:0] ret_pc_q;      // ERET target
    logic        is_eret_q;
    logic        need_badv_q;

    // Event detection
    logic        idle;
    logic        int_pend;
    logic        exc_req;
    logic        event_req;
    logic        eret_take;
    logic [4:0]  sel_code;
    logic        sel_badv;

    // Output drivers
    logic              mtc0_ack;
    logic              cp0_we;
    logic [ADDR_W-1:0] cp0_waddr;
    logic [31:0]       cp0_wdata;
    logic              flush;
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    assign idle     = (state == S_IDLE);
    assign int_pend = bus.status_i[0] & ~bus.status_i[1]
                    & (|(bus.cause_i[15:8] & bus.status_i[15:8]));

    // Only a valid commit slot can raise an event; nothing is taken while
    // the sequencer is busy or the block is held in reset.
    assign exc_req   = rst & idle & bus.exc_int_en_i
                     & (int_pend | (|bus.exc_flags_i));
    assign eret_take = rst & idle & bus.exc_int_en_i & bus.eret_i & ~exc_req;
    assign event_req = exc_req | eret_take;

    // Fixed-priority selection of the exception code and BadVAddr need
    always_comb begin
        sel_code = EXC_INT;
        sel_badv = 1'b0;
        if (int_pend) begin
            sel_code = EXC_INT;
        end else if (bus.exc_flags_i[0]) begin      // AdEL on fetch
            sel_code = EXC_ADEL;
            sel_badv = 1'b1;
        end else if (bus.exc_flags_i[1]) begin      // reserved instruction
            sel_code = EXC_RI;
        end else if (bus.exc_flags_i[2]) begin      // overflow
            sel_code = EXC_OV;
        end else if (bus.exc_flags_i[3]) begin      // syscall
            sel_code = EXC_SYS;
        end else if (bus.exc_flags_i[4]) begin      // break
            sel_code = EXC_BP;
        end else if (bus.exc_flags_i[5]) begin      // AdEL on data
            sel_code = EXC_ADEL;
            sel_badv = 1'b1;
        end else if (bus.exc_flags_i[6]) begin      // AdES
            sel_code = EXC_ADES;
            sel_badv = 1'b1;
        end
    end

    // Capture the faulting context on the accept cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            excode_q    <= 5'd0;
            bd_q        <= 1'b0;
            cause_hi_q  <= 24'd0;
            epc_val_q   <= 32'd0;
            badv_q      <= 32'd0;
            status_q    <= 32'd0;
            ret_pc_q    <= 32'd0;
            is_eret_q   <= 1'b0;
            need_badv_q <= 1'b0;
        end else if (event_req) begin
            excode_q    <= sel_code;
            // A nested exception must not disturb the BD bit of the
            // original fault, so keep the old one when EXL is set.
            bd_q        <= bus.status_i[1] ? bus.cause_i[31]
                                           : bus.in_delay_slot_i;
            cause_hi_q  <= bus.cause_i[30:7];
            // Delay-slot faults restart at the branch; wraps modulo 2^32.
            epc_val_q   <= bus.in_delay_slot_i ? (bus.pc_i - 32'd4)
                                               : bus.pc_i;
            badv_q      <= bus.badvaddr_i;
            status_q    <= bus.status_i;
            ret_pc_q    <= bus.epc_i;
            is_eret_q   <= eret_take;
            need_badv_q <= exc_req & sel_badv;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, write-port mux, arbitration and pipeline control
    always_comb begin
        state_nxt      = state;
        mtc0_ack       = 1'b0;
        cp0_we         = 1'b0;
        cp0_waddr      = '0;
        cp0_wdata      = 32'd0;
        flush          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Everything stays quiet while reset is asserted.
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (exc_req) begin
                        flush     = 1'b1;
                        stall     = 1'b1;
                        // Already at EXL: EPC keeps the outer return point.
                        state_nxt = bus.status_i[1] ? S_WR_CAUSE : S_WR_EPC;
                    end else if (eret_take) begin
                        flush     = 1'b1;
                        stall     = 1'b1;
                        state_nxt = S_WR_STATUS;
                    end else if (bus.mtc0_req_i) begin
                        mtc0_ack  = 1'b1;
                        cp0_we    = 1'b1;
                        cp0_waddr = bus.mtc0_addr_i;
                        cp0_wdata = bus.mtc0_data_i;
                    end
                end
                S_WR_EPC: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_waddr = ADDR_EPC;
                    cp0_wdata = epc_val_q;
                    state_nxt = S_WR_CAUSE;
                end
                S_WR_CAUSE: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_waddr = ADDR_CAUSE;
                    cp0_wdata = {bd_q, cause_hi_q, excode_q, 2'b00};
                    state_nxt = S_WR_STATUS;
                end
                S_WR_STATUS: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_waddr = ADDR_STATUS;
                    cp0_wdata = is_eret_q ? (status_q & ~32'h2)
                                          : (status_q |  32'h2);
                    state_nxt = need_badv_q ? S_WR_BADV : S_REDIRECT;
                end
                S_WR_BADV: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_waddr = ADDR_BADV;
                    cp0_wdata = badv_q;
                    state_nxt = S_REDIRECT;
                end
                S_REDIRECT: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = is_eret_q ? ret_pc_q : EXC_VECTOR;
                    state_nxt      = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.mtc0_ack_o       = mtc0_ack;
    assign bus.cp0_we_o         = cp0_we;
    assign bus.cp0_waddr_o      = cp0_waddr;
    assign bus.cp0_wdata_o      = cp0_wdata;
    assign bus.flush_o          = flush;
    assign bus.stall_o          = stall;
    assign bus.redirect_valid_o = redirect_valid;
    assign bus.redirect_pc_o    = redirect_pc;

endmodule
`default_nettype wire
